// File: rtl/syn_loadable_down_counter.sv
// syn_loadable_down_counter: loadable down counter/timer with terminal-count pulse and optional auto-reload
module syn_loadable_down_counter #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d_in,
    output logic [WIDTH-1:0] o_d_out,
    output logic             o_zero,
    output logic             o_tc,
    output logic             o_busy
);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_d_out;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;
    logic             r_busy;
    // count state machine: reset > load > enabled decrement/reload > hold; tc and busy registered alongside
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_d_out  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
        end else if (i_load) begin
            r_d_out  <= i_d_in;
            r_reload <= i_d_in;
            r_tc     <= 1'b0;
            r_state  <= (i_d_in != '0) ? COUNT : DONE;
            r_busy   <= (i_d_in != '0);
        end else if (r_state == COUNT && i_en) begin
            if (r_d_out > WIDTH'(1)) begin
                r_d_out <= r_d_out - WIDTH'(1);
                r_tc    <= 1'b0;
            end else if (r_d_out == WIDTH'(1)) begin
                r_d_out <= '0;
                r_tc    <= 1'b1;
                if (!AUTO_RELOAD) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                end
            end else begin
                r_d_out <= AUTO_RELOAD ? r_reload : r_d_out;
                r_tc    <= 1'b0;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end
    assign o_d_out = r_d_out;
    assign o_zero  = (r_d_out == '0);
    assign o_tc    = r_tc;
    assign o_busy  = r_busy;
endmodule
